// File: rtl/clock_div_prog.sv
// Programmable tick / square-wave divider with a shadowed, glitch-free divisor.
// A new divisor only lands in div_cur at a period wrap or on restart.
module clock_div_prog #(
   parameter int unsigned WIDTH       = 28,
   parameter int unsigned DEFAULT_DIV = 200000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             restart_i,
   input  logic             div_load_i,
   input  logic [WIDTH-1:0] div_in_i,
   output logic             tick_o,
   output logic             sq_o,
   output logic [WIDTH-1:0] div_cur_o
);

   localparam logic [WIDTH-1:0] DIV_RST = (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   logic [WIDTH-1:0] din_clamp;
   logic [WIDTH-1:0] nd;
   logic [WIDTH:0]   half;
   logic             wrap;
   logic             at_half;

   assign din_clamp = (div_in_i == '0) ? ONE : div_in_i;
   // A load on the same edge as a wrap/restart bypasses the shadow register.
   assign nd        = div_load_i ? din_clamp : div_shadow_q;
   // One extra bit keeps (div+1)>>1 correct for an all-ones divisor.
   assign half      = ({1'b0, div_cur_q} + (WIDTH+1)'(1)) >> 1;
   assign wrap      = (cnt_q >= div_cur_q);
   assign at_half   = ({1'b0, cnt_q} == half);

   always_comb begin
      cnt_d        = cnt_q;
      div_cur_d    = div_cur_q;
      div_shadow_d = div_load_i ? din_clamp : div_shadow_q;
      tick_d       = 1'b0;
      sq_d         = sq_q;
      if (restart_i) begin
         cnt_d     = ONE;
         sq_d      = 1'b0;
         div_cur_d = nd;
      end else if (en_i) begin
         if (wrap) begin
            cnt_d     = ONE;
            tick_d    = 1'b1;
            sq_d      = 1'b1;
            div_cur_d = nd;
         end else begin
            cnt_d = cnt_q + ONE;
            if (at_half) begin
               sq_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= ONE;
         div_cur_q    <= DIV_RST;
         div_shadow_q <= DIV_RST;
         tick_q       <= 1'b0;
         sq_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         div_cur_q    <= div_cur_d;
         div_shadow_q <= div_shadow_d;
         tick_q       <= tick_d;
         sq_q         <= sq_d;
      end
   end

   assign tick_o    = tick_q;
   assign sq_o      = sq_q;
   assign div_cur_o = div_cur_q;

endmodule
